// File: rtl/adxl357_acc_averager.sv
// Boxcar averager for ADXL357 X/Y/Z bursts: captures on the controller finish fall,
// averages 2^n samples and flags a stalled sensor. Offset correction: ADXL357_OFFSET_CORR_EN.
module adxl357_acc_averager #(
  parameter int TIMEOUT_CYC = 500000,
  parameter int ACC_W       = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [2:0]              i_avg_sel,
  input  logic                    i_finish,
  input  logic signed [ACC_W-1:0] i_accx,
  input  logic signed [ACC_W-1:0] i_accy,
  input  logic signed [ACC_W-1:0] i_accz,
  input  logic                    i_clr_timeout,
`ifdef ADXL357_OFFSET_CORR_EN
  input  logic signed [19:0]      i_offx,
  input  logic signed [19:0]      i_offy,
  input  logic signed [19:0]      i_offz,
`endif
  output logic signed [ACC_W-1:0] o_accx,
  output logic signed [ACC_W-1:0] o_accy,
  output logic signed [ACC_W-1:0] o_accz,
  output logic                    o_valid,
  output logic [7:0]              o_sample_cnt,
  output logic                    o_timeout,
  output logic                    o_overrun
);

  localparam int AW   = ACC_W + 7;
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_OUT} state_t;

  state_t               state;
  logic                 f1, f2, f3;
  logic                 fin_fall;
  logic [2:0]           n_lat;
  logic [7:0]           cnt;
  logic signed [AW-1:0] acc_x, acc_y, acc_z;
  logic signed [AW-1:0] term_x, term_y, term_z;
  logic signed [AW-1:0] sh_x, sh_y, sh_z;
  logic                 last_sample;
  logic [WD_W-1:0]      wd_cnt;
  logic                 wd_set;

  // finish comes from the i2c clock domain; the falling edge marks stable data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f1 <= 1'b0;
      f2 <= 1'b0;
      f3 <= 1'b0;
    end else begin
      f1 <= i_finish;
      f2 <= f1;
      f3 <= f2;
    end
  end

  assign fin_fall = f3 & ~f2;

`ifdef ADXL357_OFFSET_CORR_EN
  assign term_x = {{7{i_accx[ACC_W-1]}}, i_accx} - {{(AW-20){i_offx[19]}}, i_offx};
  assign term_y = {{7{i_accy[ACC_W-1]}}, i_accy} - {{(AW-20){i_offy[19]}}, i_offy};
  assign term_z = {{7{i_accz[ACC_W-1]}}, i_accz} - {{(AW-20){i_offz[19]}}, i_offz};
`else
  assign term_x = {{7{i_accx[ACC_W-1]}}, i_accx};
  assign term_y = {{7{i_accy[ACC_W-1]}}, i_accy};
  assign term_z = {{7{i_accz[ACC_W-1]}}, i_accz};
`endif

  assign sh_x        = acc_x >>> n_lat;
  assign sh_y        = acc_y >>> n_lat;
  assign sh_z        = acc_z >>> n_lat;
  assign last_sample = (({1'b0, cnt} + 9'd1) == (9'd1 << n_lat));
  assign o_sample_cnt = cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      n_lat     <= '0;
      cnt       <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      acc_z     <= '0;
      o_accx    <= '0;
      o_accy    <= '0;
      o_accz    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_en) begin
        state     <= S_IDLE;
        cnt       <= '0;
        acc_x     <= '0;
        acc_y     <= '0;
        acc_z     <= '0;
        o_overrun <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt   <= '0;
            acc_x <= '0;
            acc_y <= '0;
            acc_z <= '0;
            n_lat <= i_avg_sel;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (fin_fall) state <= S_ACC;
          end
          S_ACC: begin
            acc_x <= acc_x + term_x;
            acc_y <= acc_y + term_y;
            acc_z <= acc_z + term_z;
            // the final sample leaves cnt alone so it never exceeds 127
            if (last_sample) begin
              state <= S_OUT;
            end else begin
              cnt   <= cnt + 8'd1;
              state <= S_WAIT;
            end
            if (fin_fall) o_overrun <= 1'b1;
          end
          S_OUT: begin
            o_accx  <= sh_x[ACC_W-1:0];
            o_accy  <= sh_y[ACC_W-1:0];
            o_accz  <= sh_z[ACC_W-1:0];
            o_valid <= 1'b1;
            cnt     <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            acc_z   <= '0;
            n_lat   <= i_avg_sel;
            state   <= S_WAIT;
            if (fin_fall) o_overrun <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // threshold fires once on arrival; a fresh fall beats it, and it beats a clear
  assign wd_set = i_en && !fin_fall && (wd_cnt == WD_MAX - WD_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else if (!i_en) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (fin_fall)
        wd_cnt <= '0;
      else if (wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_set)
        o_timeout <= 1'b1;
      else if (i_clr_timeout)
        o_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adxl357_acc_averager.sv
// Randomized self-checking bench for adxl357_acc_averager against a window/floor-division model.
// Also exercises offset correction when ADXL357_OFFSET_CORR_EN is defined.
module tb_adxl357_acc_averager;

  localparam int ACC_W = 32;
  localparam int TO    = 1000;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic                    i_en;
  logic [2:0]              i_avg_sel;
  logic                    i_finish;
  logic signed [ACC_W-1:0] i_accx, i_accy, i_accz;
  logic                    i_clr_timeout;
`ifdef ADXL357_OFFSET_CORR_EN
  logic signed [19:0]      i_offx, i_offy, i_offz;
`endif
  logic signed [ACC_W-1:0] o_accx, o_accy, o_accz;
  logic                    o_valid;
  logic [7:0]              o_sample_cnt;
  logic                    o_timeout;
  logic                    o_overrun;

  adxl357_acc_averager #(.TIMEOUT_CYC(TO), .ACC_W(ACC_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_avg_sel(i_avg_sel),
    .i_finish(i_finish), .i_accx(i_accx), .i_accy(i_accy), .i_accz(i_accz),
    .i_clr_timeout(i_clr_timeout),
`ifdef ADXL357_OFFSET_CORR_EN
    .i_offx(i_offx), .i_offy(i_offy), .i_offz(i_offz),
`endif
    .o_accx(o_accx), .o_accy(o_accy), .o_accz(o_accz), .o_valid(o_valid),
    .o_sample_cnt(o_sample_cnt), .o_timeout(o_timeout), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {longint x; longint y; longint z;} trip_t;

  int     tests_run = 0;
  int     tests_failed = 0;
  int     valid_seen = 0;
  trip_t  exp_q[$];
  trip_t  mon_t;
  longint sum_x, sum_y, sum_z;
  int     m_cnt;
  int     m_n;

  task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic longint floorDiv(input longint s, input int n);
    longint d, q;
    d = 1;
    for (int i = 0; i < n; i++) d = d * 2;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint trunc32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  // a new window takes its size from i_avg_sel at the moment it opens
  task automatic modelOpen();
    sum_x = 0; sum_y = 0; sum_z = 0;
    m_cnt = 0;
    m_n   = int'(i_avg_sel);
  endtask

  task automatic modelAdd(input logic signed [31:0] x, y, z);
    trip_t t;
`ifdef ADXL357_OFFSET_CORR_EN
    sum_x += longint'(x) - longint'(i_offx);
    sum_y += longint'(y) - longint'(i_offy);
    sum_z += longint'(z) - longint'(i_offz);
`else
    sum_x += longint'(x);
    sum_y += longint'(y);
    sum_z += longint'(z);
`endif
    m_cnt++;
    if (m_cnt == (1 << m_n)) begin
      t.x = trunc32(floorDiv(sum_x, m_n));
      t.y = trunc32(floorDiv(sum_y, m_n));
      t.z = trunc32(floorDiv(sum_z, m_n));
      exp_q.push_back(t);
      modelOpen();
    end
  endtask

  // every valid pulse must match the oldest completed window
  always @(posedge i_clk) begin
    #1;
    if (o_valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        mon_t = exp_q.pop_front();
        checkOutput("avg_x", o_accx, mon_t.x);
        checkOutput("avg_y", o_accy, mon_t.y);
        checkOutput("avg_z", o_accz, mon_t.z);
      end
    end
  end

  // one burst read: finish high, then the fall; valid must appear only after edge k+4
  task automatic applyStimulus(input logic signed [31:0] x, y, z);
    logic [5:0] vbits;
    bit         closes;
    @(negedge i_clk);
    i_accx = x; i_accy = y; i_accz = z;
    i_finish = 1'b1;
    repeat (4) @(negedge i_clk);
    i_finish = 1'b0;
    closes = ((m_cnt + 1) == (1 << m_n));
    modelAdd(x, y, z);
    vbits = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk);
      #1;
      vbits[i] = o_valid;
    end
    checkOutput("valid_timing", vbits, closes ? 64'sd16 : 64'sd0);
    checkOutput("sample_cnt", o_sample_cnt, m_cnt);
  endtask

  task automatic enableCycle();
    @(negedge i_clk);
    i_en = 1'b0;
    @(negedge i_clk);
    i_en = 1'b1;
    modelOpen();
  endtask

  int v0;

  initial begin
    i_rst_n = 1'b0; i_en = 1'b0; i_avg_sel = 3'd0; i_finish = 1'b0;
    i_accx = '0; i_accy = '0; i_accz = '0; i_clr_timeout = 1'b0;
`ifdef ADXL357_OFFSET_CORR_EN
    i_offx = '0; i_offy = '0; i_offz = '0;
`endif
    modelOpen();
    repeat (3) @(negedge i_clk);
    checkOutput("rst_accx", o_accx, 0);
    checkOutput("rst_accy", o_accy, 0);
    checkOutput("rst_accz", o_accz, 0);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_cnt", o_sample_cnt, 0);
    checkOutput("rst_timeout", o_timeout, 0);
    checkOutput("rst_overrun", o_overrun, 0);
    i_rst_n = 1'b1;

    // pass-through with the full-scale 20-bit values
    i_avg_sel = 3'd0;
    enableCycle();
    applyStimulus(524287, -524288, 0);
    checkOutput("t1_accx", o_accx, 524287);
    checkOutput("t1_accy", o_accy, -524288);
    checkOutput("t1_accz", o_accz, 0);

    // four-sample window with a negative floor
    i_avg_sel = 3'd2;
    enableCycle();
    applyStimulus(-1, 10, 0);
    applyStimulus(-1, 20, 0);
    applyStimulus(-1, 30, 0);
    applyStimulus(-2, 40, 0);
    checkOutput("t2_accx", o_accx, -2);
    checkOutput("t2_accy", o_accy, 25);

    // aborted partial window produces nothing
    v0 = valid_seen;
    enableCycle();
    applyStimulus(5000, 5000, 5000);
    applyStimulus(5000, 5000, 5000);
    enableCycle();
    for (int i = 0; i < 4; i++) applyStimulus(100, 100, 100);
    checkOutput("t4_valids", valid_seen - v0, 1);
    checkOutput("t4_accx", o_accx, 100);

    // window size changes only at the next window
    v0 = valid_seen;
    enableCycle();
    applyStimulus(7, 7, 7);
    i_avg_sel = 3'd0;
    for (int i = 0; i < 3; i++) applyStimulus(8, 9, 10);
    checkOutput("t5_first", valid_seen - v0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(i * 3 - 4, 11, -12);
    checkOutput("t5_valids", valid_seen - v0, 4);

    // offset correction (or raw pass-through without it)
`ifdef ADXL357_OFFSET_CORR_EN
    i_offx = 20'sd1000;
`endif
    applyStimulus(1500, 0, 0);
`ifdef ADXL357_OFFSET_CORR_EN
    checkOutput("t6_accx", o_accx, 500);
    i_offx = '0;
`else
    checkOutput("t6_accx", o_accx, 1500);
`endif

    // second fall lands while the first sample is being output: dropped, overrun
    v0 = valid_seen;
    @(negedge i_clk);
    i_accx = 33; i_accy = 44; i_accz = 55;
    i_finish = 1'b1;
    repeat (4) @(negedge i_clk);
    i_finish = 1'b0;
    modelAdd(33, 44, 55);
    @(negedge i_clk);
    i_finish = 1'b1;
    @(negedge i_clk);
    i_finish = 1'b0;
    repeat (8) @(negedge i_clk);
    checkOutput("ovr_set", o_overrun, 1);
    checkOutput("ovr_valids", valid_seen - v0, 1);
    enableCycle();
    @(negedge i_clk);
    checkOutput("ovr_clr", o_overrun, 0);

    // watchdog: sets after TO enabled cycles, clear pulse, fall resets the count
    enableCycle();
    repeat (TO - 1) @(posedge i_clk);
    #1 checkOutput("wd_before", o_timeout, 0);
    @(posedge i_clk);
    #1 checkOutput("wd_set", o_timeout, 1);
    @(negedge i_clk);
    i_clr_timeout = 1'b1;
    @(negedge i_clk);
    i_clr_timeout = 1'b0;
    checkOutput("wd_clr", o_timeout, 0);
    repeat (TO - 12) @(negedge i_clk);
    applyStimulus(1, 2, 3);
    repeat (10) @(negedge i_clk);
    checkOutput("wd_stay", o_timeout, 0);

    // randomized windows with occasional size changes and enable drops
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 7) == 0) i_avg_sel = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) enableCycle();
`ifdef ADXL357_OFFSET_CORR_EN
      i_offx = 20'($urandom); i_offy = 20'($urandom); i_offz = 20'($urandom);
`endif
      applyStimulus($urandom, $urandom, $urandom);
    end

    // a long window to reach the top of the sample counter range
    i_avg_sel = 3'd7;
    enableCycle();
    for (int r = 0; r < 128; r++) applyStimulus($urandom, $urandom, $urandom);

    // reset in the middle of a window clears everything at once
    i_avg_sel = 3'd2;
    enableCycle();
    applyStimulus(-3000, 4000, 123);
    applyStimulus(-3000, 4000, 123);
    v0 = valid_seen;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_accx", o_accx, 0);
    checkOutput("mid_rst_accy", o_accy, 0);
    checkOutput("mid_rst_accz", o_accz, 0);
    checkOutput("mid_rst_cnt", o_sample_cnt, 0);
    checkOutput("mid_rst_valid", o_valid, 0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    modelOpen();
    repeat (10) @(negedge i_clk);
    checkOutput("mid_rst_novalid", valid_seen - v0, 0);
    checkOutput("pending", exp_q.size(), 0);
    checkOutput("final_overrun", o_overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
